manual_drive_ctrl: RTL
======================

MANUAL_DRIVE_CTRL -- requirements
Module: manual_drive_ctrl

Interface
REQ-001 The block SHALL expose parameter START_HOLD, default 4, the consecutive cycles of the start condition required to leave NSTART.
REQ-002 The block SHALL expose parameter SPEED_W, default 4, the width of the speed output.
REQ-003 The block SHALL expose parameter ACCEL_DIV, default 2, the cycles per speed step (ramp up or coast down).
REQ-004 The block SHALL expose parameter BLINK_HALF, default 8, the turn-light half-period in cycles.
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge.
 rst  in  1  asynchronous, active-high reset.
 power  in  1  power switch, 1 = on.
 clutch, brake, throttle, rgs, left, right  in  1 each  driver controls (rgs = reverse gear).
 state  out  2  OFF=11, NSTART=00, START=01, MOVING=10.
 moving_state  out  4  NON_MOVING=0000, FORWARD=0001, BACK=0010, TURN_LEFT=0100, TURN_RIGHT=1000.
 stall  out  1  one-cycle pulse on engine stall.
 speed  out  SPEED_W  current speed level.
 turn_left_light, turn_right_light  out  1 each  indicators.
 state_light  out  3  one-hot NSTART=001, START=010, MOVING=100; 000 in OFF.
 moving_light  out  4  equals moving_state.

Function
REQ-006 All outputs SHALL be driven from registers only; an input sampled at edge N affects outputs after edge N.
REQ-007 In any state, a sampled power of 0 SHALL move the block to OFF with speed 0 and moving_state NON_MOVING; this has top priority.
REQ-008 OFF SHALL go to NSTART only on a power rising edge (registered power_q=0, power=1); power held at 1 after a stall keeps the block in OFF.
REQ-009 NSTART priority: brake -> stay, clear hold counter; throttle&~clutch -> stall pulse, go to OFF; throttle&clutch&~rgs -> increment hold counter, go to START when the count reaches START_HOLD; otherwise -> clear hold counter.
REQ-010 START priority: brake -> NSTART; throttle&~clutch -> MOVING, with direction given by REQ-012; otherwise -> stay.
REQ-011 MOVING priority: rgs&~clutch -> stall pulse, go to OFF; brake -> NSTART; ~throttle -> START; otherwise -> stay, with direction updated per REQ-012.
REQ-012 Direction rules:
 - rgs gives BACK.
 - left&~right gives TURN_LEFT.
 - right&~left gives TURN_RIGHT.
 - otherwise FORWARD.
 - A change between BACK and a non-BACK direction inside MOVING SHALL take effect only when speed==0; otherwise the previous direction is kept.
REQ-013 Speed in MOVING with throttle SHALL increment once every ACCEL_DIV cycles and saturate at 2^SPEED_W-1.
REQ-014 Speed in START SHALL decrement once every ACCEL_DIV cycles and saturate at 0.
REQ-015 Speed in NSTART or OFF SHALL be 0; the divider counter SHALL clear on every state change.
REQ-016 moving_state SHALL be NON_MOVING in OFF, NSTART and START, except that it holds the last MOVING direction in START while speed>0.
REQ-017 Turn lights:
 - NSTART: both on.
 - OFF: both off.
 - BACK: both off.
 - START and MOVING: left light = left, right light = right.
REQ-018 stall SHALL be high for exactly one cycle per stall event.

Reset
REQ-019 While rst is high, the block SHALL hold state=OFF, power_q=1, speed=0, moving_state=NON_MOVING, stall=0, all lights 0, and all counters 0; power_q=1 means a power rising edge is needed after reset.

Configuration
REQ-020 With MANUAL_BLINK_EN defined, every turn light that REQ-017 sets on SHALL toggle every BLINK_HALF cycles from a free-running counter; it SHALL start on after reset, and both lights SHALL blink in phase.
REQ-021 Without MANUAL_BLINK_EN, turn lights SHALL be steady and the blink counter SHALL not exist.

Verification
REQ-022 Reset, then power 0->1 -> state OFF then NSTART; state_light=001; both turn lights 1.
REQ-023 In NSTART, throttle=clutch=1 for 3 cycles then drop -> stay NSTART; held 4 cycles -> START, state_light=010.
REQ-024 In START, clutch=0, throttle=1, left=1 -> MOVING, moving_state=0100; speed reaches 15 after 30 cycles and stays 15.
REQ-025 In MOVING at speed=5, rgs=1, clutch=1 -> direction stays FORWARD; throttle=0 coasts speed to 0 in START; back in MOVING -> moving_state=0010.
REQ-026 In MOVING, rgs=1, clutch=0 -> stall=1 for one cycle, state=OFF, speed=0; power held at 1 -> OFF persists; power 0->1 -> NSTART.
REQ-027 With MANUAL_BLINK_EN defined, right=1 in MOVING -> turn_right_light toggles every 8 cycles and turn_left_light=0.

Source files
------------

// File: rtl/manual_drive_ctrl.sv
// Manual-gearbox drive controller: engine start/stall FSM, speed ramp, direction and lights.
// Optional MANUAL_BLINK_EN makes the turn lights blink from a free-running counter.
module manual_drive_ctrl #(
    parameter int START_HOLD = 4,
    parameter int SPEED_W    = 4,
    parameter int ACCEL_DIV  = 2,
    parameter int BLINK_HALF = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               power,
    input  logic               clutch,
    input  logic               brake,
    input  logic               throttle,
    input  logic               rgs,
    input  logic               left,
    input  logic               right,
    output logic [1:0]         state,
    output logic [3:0]         moving_state,
    output logic               stall,
    output logic [SPEED_W-1:0] speed,
    output logic               turn_left_light,
    output logic               turn_right_light,
    output logic [2:0]         state_light,
    output logic [3:0]         moving_light
);

    localparam logic [1:0] ST_OFF    = 2'b11;
    localparam logic [1:0] ST_NSTART = 2'b00;
    localparam logic [1:0] ST_START  = 2'b01;
    localparam logic [1:0] ST_MOVING = 2'b10;

    localparam logic [3:0] MV_NONE  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_BACK  = 4'b0010;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    localparam int HOLD_W = $clog2(START_HOLD + 1);
    localparam int DIV_W  = $clog2(ACCEL_DIV + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(ACCEL_DIV - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

    generate
        if (START_HOLD < 1 || ACCEL_DIV < 1 || BLINK_HALF < 1 || SPEED_W < 1) begin : g_bad_param
            $error("manual_drive_ctrl: parameters must all be >= 1");
        end
    endgenerate

    logic [1:0]         state_reg, state_next;
    logic               power_q_reg;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic [SPEED_W-1:0] speed_reg, speed_next;
    logic [3:0]         moving_state_reg, moving_state_next;
    logic               stall_reg, stall_next;
    logic               left_light_reg, right_light_reg;
    logic               left_light_next, right_light_next;
    logic [2:0]         state_light_reg, state_light_next;
    logic [3:0]         dir_req, dir_sel;
    logic               want_left, want_right;
    logic               blink_on;

    // Requested direction, then the BACK<->forward-family swap lock while still rolling.
    always_comb begin
        if (rgs)                dir_req = MV_BACK;
        else if (left && !right) dir_req = MV_LEFT;
        else if (right && !left) dir_req = MV_RIGHT;
        else                    dir_req = MV_FWD;

        dir_sel = dir_req;
        if (moving_state_reg != MV_NONE && speed_reg != '0 &&
            ((dir_req == MV_BACK) != (moving_state_reg == MV_BACK)))
            dir_sel = moving_state_reg;
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = '0;
        div_cnt_next  = '0;
        speed_next    = speed_reg;
        stall_next    = 1'b0;

        case (state_reg)
            ST_OFF: begin
                if (power && !power_q_reg)
                    state_next = ST_NSTART;
            end
            ST_NSTART: begin
                if (brake) begin
                    hold_cnt_next = '0;
                end else if (throttle && !clutch) begin
                    stall_next = 1'b1;
                    state_next = ST_OFF;
                end else if (throttle && clutch && !rgs) begin
                    if (hold_cnt_reg == HOLD_LAST)
                        state_next = ST_START;
                    else
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            ST_START: begin
                if (brake) begin
                    state_next = ST_NSTART;
                end else if (throttle && !clutch) begin
                    state_next = ST_MOVING;
                end else if (div_cnt_reg == DIV_LAST) begin
                    if (speed_reg != '0)
                        speed_next = speed_reg - 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            default: begin
                if (rgs && !clutch) begin
                    stall_next = 1'b1;
                    state_next = ST_OFF;
                end else if (brake) begin
                    state_next = ST_NSTART;
                end else if (!throttle) begin
                    state_next = ST_START;
                end else if (div_cnt_reg == DIV_LAST) begin
                    if (speed_reg != SPEED_MAX)
                        speed_next = speed_reg + 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
        endcase

        if (!power) begin
            state_next    = ST_OFF;
            stall_next    = 1'b0;
            hold_cnt_next = '0;
            div_cnt_next  = '0;
        end

        if (state_next == ST_OFF || state_next == ST_NSTART)
            speed_next = '0;
    end

    always_comb begin
        moving_state_next = MV_NONE;
        want_left         = 1'b0;
        want_right        = 1'b0;
        state_light_next  = 3'b000;
        case (state_next)
            ST_MOVING: begin
                moving_state_next = dir_sel;
                state_light_next  = 3'b100;
            end
            ST_START: begin
                // The last direction is kept visible while the car is still coasting.
                if (speed_next != '0)
                    moving_state_next = moving_state_reg;
                state_light_next = 3'b010;
            end
            ST_NSTART: begin
                want_left        = 1'b1;
                want_right       = 1'b1;
                state_light_next = 3'b001;
            end
            default: ;
        endcase
        if ((state_next == ST_START || state_next == ST_MOVING) && moving_state_next != MV_BACK) begin
            want_left  = left;
            want_right = right;
        end
        left_light_next  = want_left && blink_on;
        right_light_next = want_right && blink_on;
    end

`ifdef MANUAL_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;
    logic               blink_phase_next;

    always_comb begin
        blink_phase_next = blink_phase_reg;
        if (blink_cnt_reg == BLINK_LAST)
            blink_phase_next = !blink_phase_reg;
    end
    assign blink_on = blink_phase_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
        end else begin
            blink_phase_reg <= blink_phase_next;
            blink_cnt_reg   <= (blink_cnt_reg == BLINK_LAST) ? '0 : blink_cnt_reg + 1'b1;
        end
    end
`else
    assign blink_on = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_OFF;
            power_q_reg      <= 1'b1;
            hold_cnt_reg     <= '0;
            div_cnt_reg      <= '0;
            speed_reg        <= '0;
            moving_state_reg <= MV_NONE;
            stall_reg        <= 1'b0;
            left_light_reg   <= 1'b0;
            right_light_reg  <= 1'b0;
            state_light_reg  <= 3'b000;
        end else begin
            state_reg        <= state_next;
            power_q_reg      <= power;
            hold_cnt_reg     <= hold_cnt_next;
            div_cnt_reg      <= div_cnt_next;
            speed_reg        <= speed_next;
            moving_state_reg <= moving_state_next;
            stall_reg        <= stall_next;
            left_light_reg   <= left_light_next;
            right_light_reg  <= right_light_next;
            state_light_reg  <= state_light_next;
        end
    end

    assign state            = state_reg;
    assign moving_state     = moving_state_reg;
    assign moving_light     = moving_state_reg;
    assign stall            = stall_reg;
    assign speed            = speed_reg;
    assign turn_left_light  = left_light_reg;
    assign turn_right_light = right_light_reg;
    assign state_light      = state_light_reg;

endmodule
